// File: rtl/dmem_ws.sv
// Wait-stated byte-addressable data memory: one load/store per valid/ready handshake,
// LATENCY extra cycles before the access, then a one-cycle response strobe.
module dmem_ws #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_access;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic        w_oor;
    logic        w_misal;
    logic        w_err;
    logic [31:0] w_rword;
    logic [15:0] w_lane;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wd;

    assign w_accept  = req_valid & req_ready;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = w_accept ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing can be accepted while reset is held.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        w_access  = 1'b0;
        case (r_state)
            IDLE: req_ready = ~rst;
            BUSY: w_access  = (r_cnt == 4'd0);
            RESP: begin
                req_ready = ~rst;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 2'd0;
        end else if (w_accept) begin
            r_cnt   <= LAT;
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
        end else if (r_state == BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
    always_comb begin
        w_off   = r_addr - BASE_ADDR;
        w_idx   = w_off[AW+1:2];
        w_oor   = {2'b00, w_off[31:2]} >= 32'(DEPTH_WORDS);
        w_misal = (r_size == 2'b11) ||
                  (r_size == 2'b01 && r_addr[0]) ||
                  (r_size == 2'b10 && r_addr[1:0] != 2'b00);
        w_err   = w_misal | w_oor;
        w_rword = r_mem[w_idx];
        w_lane  = 16'(w_rword >> {r_addr[1:0], 3'b000});
    end

    always_comb begin
        w_load = w_rword;
        w_be   = 4'b1111;
        w_wd   = r_wdata;
        case (r_size)
            2'b00: begin
                w_load = r_uns ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
                w_be   = 4'b0001 << r_addr[1:0];
                w_wd   = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_load = r_uns ? {16'h0, w_lane} : {{16{w_lane[15]}}, w_lane};
                w_be   = 4'b0011 << {r_addr[1], 1'b0};
                w_wd   = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Array has no reset; a reset at the commit edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
        end
    end

endmodule
